fitness_sweeper: RTL and testbench
==================================

// Module: fitness_sweeper
// PURPOSE
//  Sequential fitness evaluator for evolved gate-level candidate circuits.
//  Sweeps every input vector of an N-input candidate and holds each vector for a settle period.
//  Compares each candidate output bit against a golden model and accumulates the matching bits as a score.
//  Sits between the evolved-candidate netlist and the evolution controller, which reads score/perfect on done.
// PARAMETERS
//  NUM_INPUTS     5  candidate input count; sweep length is 2**NUM_INPUTS vectors (range 1..16)
//  NUM_OUTPUTS    4  candidate output count, compared bitwise (range 1..32)
//  SETTLE_CYCLES  2  extra cycles each vector is held before sampling; 0 is legal (one vector per cycle)
// PORTS
//  clk            in   1            single clock, rising edge
//  reset          in   1            synchronous, active-high
//  start          in   1            begin a sweep; accepted only when busy==0
//  vector         out  NUM_INPUTS   registered input vector driven to candidate and golden model
//  candidate_out  in   NUM_OUTPUTS  candidate outputs for current vector (combinational from vector)
//  expected_out   in   NUM_OUTPUTS  golden-model outputs for current vector
//  busy           out  1            sweep in progress
//  done           out  1            sweep complete; held until next accepted start or reset
//  score          out  SCORE_W      matching output bits over whole sweep, SCORE_W = $clog2(MAX_SCORE+1)
//  perfect        out  1            score == MAX_SCORE (MAX_SCORE = NUM_OUTPUTS * 2**NUM_INPUTS)
// BEHAVIOUR
//  - Reset (synchronous, active-high) values: vector=0, busy=0, done=0, score=0, perfect=0, FSM=IDLE, hold counter=0.
//  - FSM states: IDLE, HOLD, SAMPLE, DONE.
//    IDLE/DONE --start--> HOLD.
//    HOLD --counter==0--> SAMPLE.
//    SAMPLE --vector!=all-ones--> HOLD.
//    SAMPLE --vector==all-ones--> DONE.
//  - Accepted start (edge t): score<=0, vector<=0, busy<=1, done<=0, perfect<=0, hold counter<=SETTLE_CYCLES.
//  - start while busy==1: ignored, no effect on sweep or score.
//  - Each vector is driven for exactly SETTLE_CYCLES+1 cycles.
//    On the last of those edges, score += popcount(~(candidate_out ^ expected_out)).
//    On that same edge, vector increments and the hold counter reloads.
//  - The final sample is on vector == 2**NUM_INPUTS-1. On that edge:
//    busy<=0, done<=1, perfect<=(final score==MAX_SCORE), vector<=0 (wraps, never exceeds range).
//  - Latency: done rises at edge t + (2**NUM_INPUTS)*(SETTLE_CYCLES+1).
//  - score width: SCORE_W bits, sized to hold MAX_SCORE exactly; no saturation needed, cannot overflow.
//  - score, perfect: stable from done rise until the next accepted start.
//  - reset and start in the same cycle: reset wins.
//  - reset mid-sweep: abort immediately to reset values; no partial score retained.
//  - start in the same cycle done rises: not accepted (busy still 1 that cycle).
//  - start while done==1: accepted and restarts cleanly.
//  - candidate_out/expected_out are sampled only on SAMPLE edges; values at other times are don't-care.
// STRUCTURE
//  - evolverilog_pkg holds:
//    - FSM state enum {IDLE,HOLD,SAMPLE,DONE};
//    - functions max_score(ni,no) and score_w(ni,no).
//  - Sub-module match_count (combinational):
//    - NUM_OUTPUTS-wide XNOR and popcount;
//    - output width $clog2(NUM_OUTPUTS+1).
//  - Top module holds the FSM, hold counter, vector register and score accumulator.
// TESTING
//  1. Defaults, candidate_out wired to expected_out, start at edge 10:
//     done rises at edge 106 (32*3 cycles); score=128, perfect=1.
//  2. Defaults, candidate output3 inverted vs golden:
//     score=96, perfect=0.
//  3. Defaults, candidate_out = ~expected_out for every vector:
//     score=0, done timing as in test 1.
//  4. reset at edge 40 mid-sweep:
//     next cycle busy=0, done=0, score=0, vector=0.
//     A subsequent start runs a full sweep; score=128 with matching candidate.
//  5. start pulsed at edges 20, 50, 90 during a sweep:
//     sweep unaffected; done still at edge 106, score=128.
//  6. NUM_INPUTS=2, NUM_OUTPUTS=1, SETTLE_CYCLES=0, matching candidate:
//     vector 0,1,2,3 on consecutive cycles; done 4 edges after start, score=4, perfect=1.
//     A back-to-back start while done=1 restarts cleanly.

Source files
------------

// File: rtl/evolverilog_pkg.sv
// evolverilog_pkg: shared FSM state type and score sizing helpers for the fitness sweeper.
package evolverilog_pkg;
  typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, DONE} state_t;
  function automatic int max_score(input int ni, input int no);
    return no * (2 ** ni);
  endfunction
  function automatic int score_w(input int ni, input int no);
    return $clog2(max_score(ni, no) + 1);
  endfunction
endpackage

// File: rtl/match_count.sv
// match_count: counts bit positions where candidate and golden outputs agree.
module match_count #(
  parameter int NUM_OUTPUTS = 4,
  localparam int CW = $clog2(NUM_OUTPUTS + 1)
) (
  input  logic [NUM_OUTPUTS-1:0] a,
  input  logic [NUM_OUTPUTS-1:0] b,
  output logic [CW-1:0]          count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_OUTPUTS; i++) count = count + CW'(a[i] ~^ b[i]);
  end
endmodule

// File: rtl/fitness_sweeper.sv
// fitness_sweeper: sweeps all input vectors of a candidate, holding each for a settle period,
// and accumulates the number of output bits matching the golden model.
module fitness_sweeper import evolverilog_pkg::*; #(
  parameter int NUM_INPUTS    = 5,
  parameter int NUM_OUTPUTS   = 4,
  parameter int SETTLE_CYCLES = 2,
  localparam int SCORE_W = score_w(NUM_INPUTS, NUM_OUTPUTS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic [NUM_INPUTS-1:0]  vector,
  input  logic [NUM_OUTPUTS-1:0] candidate_out,
  input  logic [NUM_OUTPUTS-1:0] expected_out,
  output logic                   busy,
  output logic                   done,
  output logic [SCORE_W-1:0]     score,
  output logic                   perfect
);
  localparam int MAX_SCORE = max_score(NUM_INPUTS, NUM_OUTPUTS);
  localparam int CNT_W = SETTLE_CYCLES > 0 ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int MC_W = $clog2(NUM_OUTPUTS + 1);
  // With no settle period every cycle is a sample cycle, so HOLD is skipped.
  localparam state_t ENTRY = SETTLE_CYCLES == 0 ? SAMPLE : HOLD;
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [NUM_INPUTS-1:0] r_vec;
  logic [SCORE_W-1:0] r_score, w_score;
  logic r_perfect;
  logic [MC_W-1:0] w_match;
  logic w_accept, w_last, w_busy;
  assign w_busy   = r_state == HOLD || r_state == SAMPLE;
  assign w_accept = start && !w_busy;
  assign w_last   = &r_vec;
  assign w_score  = r_score + SCORE_W'(w_match);
  match_count #(.NUM_OUTPUTS(NUM_OUTPUTS)) u_match (
    .a(candidate_out),
    .b(expected_out),
    .count(w_match)
  );
  always_comb begin
    w_next = r_state;
    if (w_accept) w_next = ENTRY;
    else if (r_state == HOLD) w_next = r_cnt <= CNT_W'(1) ? SAMPLE : HOLD;
    else if (r_state == SAMPLE) w_next = w_last ? DONE : ENTRY;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_vec     <= '0;
      r_score   <= '0;
      r_perfect <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt     <= CNT_W'(SETTLE_CYCLES);
        r_vec     <= '0;
        r_score   <= '0;
        r_perfect <= 1'b0;
      end else if (r_state == HOLD) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end else if (r_state == SAMPLE) begin
        r_cnt   <= CNT_W'(SETTLE_CYCLES);
        r_vec   <= r_vec + 1'b1;
        r_score <= w_score;
        if (w_last) r_perfect <= w_score == SCORE_W'(MAX_SCORE);
      end
    end
  end
  assign vector  = r_vec;
  assign busy    = w_busy;
  assign done    = r_state == DONE;
  assign score   = r_score;
  assign perfect = r_perfect;
endmodule

// File: tb/tb_fitness_sweeper.sv
// tb_fitness_sweeper: randomized golden/fault tables checked against a sweep-level score model.
module tb_fitness_sweeper;
  logic clk = 0, reset = 1, start = 0, start2 = 0;
  logic [4:0] vector;
  logic [3:0] cand, exp_o;
  logic busy, done, perfect;
  logic [7:0] score;
  logic [1:0] vector2;
  logic cand2, exp2, busy2, done2, perfect2;
  logic [2:0] score2;
  logic [3:0] gold [32];
  logic [3:0] flt [32];
  logic gold2 [4];
  logic flt2 [4];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  assign exp_o = gold[vector];
  assign cand  = gold[vector] ^ flt[vector];
  assign exp2  = gold2[vector2];
  assign cand2 = gold2[vector2] ^ flt2[vector2];

  fitness_sweeper dut (
    .clk(clk), .reset(reset), .start(start), .vector(vector),
    .candidate_out(cand), .expected_out(exp_o),
    .busy(busy), .done(done), .score(score), .perfect(perfect)
  );

  fitness_sweeper #(.NUM_INPUTS(2), .NUM_OUTPUTS(1), .SETTLE_CYCLES(0)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .vector(vector2),
    .candidate_out(cand2), .expected_out(exp2),
    .busy(busy2), .done(done2), .score(score2), .perfect(perfect2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int mode);
    for (int v = 0; v < 32; v++) begin
      gold[v] = 4'($urandom);
      flt[v]  = mode == 0 ? 4'h0 : mode == 1 ? 4'h8 : mode == 2 ? 4'hF : 4'($urandom);
    end
  endtask

  function automatic int model_score();
    int s = 0;
    for (int v = 0; v < 32; v++) s += 4 - $countones(flt[v]);
    return s;
  endfunction

  task automatic run_sweep(input string name);
    int n = 0, want, bad_dwell = 0;
    int dwell [32];
    for (int v = 0; v < 32; v++) dwell[v] = 0;
    want = model_score();
    start = 1;
    tick();
    start = 0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_start busy=%b done=%b required busy=1 done=0", name, busy, done);
    end
    while (!done && n < 1000) begin
      dwell[vector]++;
      tick();
      n++;
    end
    for (int v = 0; v < 32; v++) if (dwell[v] != 3) bad_dwell++;
    checks++;
    if (n != 96) begin
      errors++;
      $display("FAIL %s_latency cycles=%0d required 96", name, n);
    end
    checks++;
    if (bad_dwell != 0) begin
      errors++;
      $display("FAIL %s_dwell vectors_not_held_3=%0d required 0", name, bad_dwell);
    end
    checks++;
    if (score !== 8'(want) || perfect !== (want == 128) || busy !== 1'b0 || vector !== 5'd0) begin
      errors++;
      $display("FAIL %s_result score=%0d perfect=%b busy=%b vector=%0d required score=%0d perfect=%b busy=0 vector=0",
               name, score, perfect, busy, vector, want, want == 128);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (busy !== 0 || done !== 0 || score !== 0 || perfect !== 0 || vector !== 0) begin
      errors++;
      $display("FAIL reset busy=%b done=%b score=%0d perfect=%b vector=%0d required all 0",
               busy, done, score, perfect, vector);
    end
    reset = 0;
    tick();
  endtask

  task automatic test_patterns();
    fill(0); run_sweep("match");
    fill(1); run_sweep("bit3");
    fill(2); run_sweep("inverted");
    for (int k = 0; k < 3; k++) begin
      fill(3); run_sweep("random");
    end
  endtask

  task automatic test_reset_mid();
    fill(0);
    start = 1;
    tick();
    start = 0;
    repeat (30) tick();
    checks++;
    if (score !== 8'd40 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_partial score=%0d busy=%b required score=40 busy=1", score, busy);
    end
    reset = 1;
    tick();
    reset = 0;
    checks++;
    if (busy !== 0 || done !== 0 || score !== 0 || vector !== 0 || perfect !== 0) begin
      errors++;
      $display("FAIL mid_reset busy=%b done=%b score=%0d vector=%0d required all 0", busy, done, score, vector);
    end
    tick();
    fill(0);
    run_sweep("after_reset");
  endtask

  task automatic test_reset_start();
    reset = 1;
    start = 1;
    tick();
    reset = 0;
    start = 0;
    checks++;
    if (busy !== 0 || done !== 0) begin
      errors++;
      $display("FAIL reset_wins busy=%b done=%b required busy=0 done=0", busy, done);
    end
  endtask

  task automatic test_busy_start();
    int n = 0, want;
    fill(3);
    want = model_score();
    start = 1;
    tick();
    start = 0;
    while (!done && n < 1000) begin
      start = (n == 10 || n == 40 || n == 80 || n == 95);
      tick();
      n++;
    end
    start = 0;
    checks++;
    if (n != 96 || score !== 8'(want)) begin
      errors++;
      $display("FAIL busy_start cycles=%0d score=%0d required cycles=96 score=%0d", n, score, want);
    end
    tick();
    checks++;
    if (done !== 1 || busy !== 0 || score !== 8'(want) || perfect !== (want == 128)) begin
      errors++;
      $display("FAIL done_hold done=%b busy=%b score=%0d required done=1 busy=0 score=%0d", done, busy, score, want);
    end
  endtask

  task automatic test_small();
    int want;
    for (int v = 0; v < 4; v++) begin
      gold2[v] = 1'($urandom);
      flt2[v]  = 1'b0;
    end
    start2 = 1;
    tick();
    start2 = 0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (vector2 !== 2'(k) || busy2 !== 1 || done2 !== 0) begin
        errors++;
        $display("FAIL small_seq vector=%0d busy=%b done=%b required vector=%0d busy=1 done=0", vector2, busy2, done2, k);
      end
      tick();
    end
    checks++;
    if (done2 !== 1 || busy2 !== 0 || score2 !== 3'd4 || perfect2 !== 1 || vector2 !== 0) begin
      errors++;
      $display("FAIL small_done done=%b busy=%b score=%0d perfect=%b required done=1 busy=0 score=4 perfect=1",
               done2, busy2, score2, perfect2);
    end
    want = 4;
    for (int v = 0; v < 4; v++) begin
      flt2[v] = 1'($urandom);
      want -= int'(flt2[v]);
    end
    flt2[1] = 1'b1;
    want = 4;
    for (int v = 0; v < 4; v++) want -= int'(flt2[v]);
    start2 = 1;
    tick();
    start2 = 0;
    checks++;
    if (done2 !== 0 || busy2 !== 1 || score2 !== 0 || perfect2 !== 0) begin
      errors++;
      $display("FAIL b2b_restart done=%b busy=%b score=%0d perfect=%b required done=0 busy=1 score=0 perfect=0",
               done2, busy2, score2, perfect2);
    end
    repeat (4) tick();
    checks++;
    if (done2 !== 1 || score2 !== 3'(want) || perfect2 !== 0) begin
      errors++;
      $display("FAIL b2b_result done=%b score=%0d perfect=%b required done=1 score=%0d perfect=0",
               done2, score2, perfect2, want);
    end
  endtask

  initial begin
    for (int v = 0; v < 32; v++) begin
      gold[v] = '0;
      flt[v] = '0;
    end
    for (int v = 0; v < 4; v++) begin
      gold2[v] = 0;
      flt2[v] = 0;
    end
    repeat (2) tick();
    test_reset();
    test_patterns();
    test_reset_mid();
    test_reset_start();
    test_busy_start();
    test_small();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end
endmodule
